// File: rtl/digit_entry_reg.sv
// Switch/button digit entry register: digits load MSB-first, with backspace, clear and valid/ready hand-off.
// Buttons are double-synchronised; the optional debouncer is enabled by defining DIGIT_ENTRY_DEBOUNCE_EN.
module digit_entry_reg #(
    parameter int                DATA_W       = 64,
    parameter int                DIGIT_W      = 4,
    parameter int                NDIG_W       = 5,
    parameter logic [DATA_W-1:0] RESET_VALUE  = 64'h0123456789ABCDEF,
    parameter logic [15:0]       DEBOUNCE_CYC = 16'd50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIGIT_W-1:0] din,
    input  logic               load_n,
    input  logic               backspace_n,
    input  logic               clear_n,
    output logic [DATA_W-1:0]  values,
    output logic [NDIG_W-1:0]  n_entered,
    output logic               valid,
    input  logic               ready,
    output logic               err,
    output logic [3:0]         state
);
    localparam int                NDIG_I = DATA_W / DIGIT_W;
    localparam logic [NDIG_W-1:0] NDIG   = NDIG_W'(NDIG_I);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        WRITE   = 4'd1,
        ADVANCE = 4'd2,
        HOLD_LD = 4'd3,
        CHECK   = 4'd4,
        FULL    = 4'd5,
        CLEAR   = 4'd6,
        RETRACT = 4'd7,
        HOLD_BS = 4'd8,
        ERROR   = 4'd9
    } st_t;

    st_t        st;
    logic [2:0] sync1, sync2, btn_lvl;
    logic       ld, bs, cl;

    // Bit order in the button vectors: {load, backspace, clear}; released = 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 3'b111;
            sync2 <= 3'b111;
        end else begin
            sync1 <= {load_n, backspace_n, clear_n};
            sync2 <= sync1;
        end
    end

`ifdef DIGIT_ENTRY_DEBOUNCE_EN
    logic [15:0] deb_cnt [3];

    for (genvar b = 0; b < 3; b++) begin : g_deb
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                deb_cnt[b] <= '0;
                btn_lvl[b] <= 1'b1;
            end else if (sync2[b] == btn_lvl[b]) begin
                deb_cnt[b] <= '0;
            end else if (deb_cnt[b] >= DEBOUNCE_CYC - 16'd1) begin
                deb_cnt[b] <= '0;
                btn_lvl[b] <= sync2[b];
            end else begin
                deb_cnt[b] <= deb_cnt[b] + 16'd1;
            end
        end
    end
`else
    assign btn_lvl = sync2;
`endif

    assign ld    = ~btn_lvl[2];
    assign bs    = ~btn_lvl[1];
    assign cl    = ~btn_lvl[0];
    assign state = st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            values    <= RESET_VALUE;
            n_entered <= '0;
            valid     <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (ld)
                        st <= WRITE;
                    else if (bs)
                        st <= (n_entered != '0) ? RETRACT : HOLD_BS;
                    else if (cl)
                        st <= CLEAR;
                end
                WRITE: begin
                    for (int k = 0; k < NDIG_I; k++)
                        if (n_entered == NDIG_W'(k))
                            values[(NDIG_I-1-k)*DIGIT_W +: DIGIT_W] <= din;
                    st <= ADVANCE;
                end
                ADVANCE: begin
                    if (n_entered != NDIG)
                        n_entered <= n_entered + 1'b1;
                    st <= HOLD_LD;
                end
                HOLD_LD: begin
                    if (!ld)
                        st <= CHECK;
                end
                CHECK: begin
                    if (n_entered == NDIG) begin
                        st    <= FULL;
                        valid <= 1'b1;
                    end else begin
                        st <= IDLE;
                    end
                end
                // Handshake beats an edit: an accepted value must not be altered.
                FULL: begin
                    if (ready) begin
                        st    <= CLEAR;
                        valid <= 1'b0;
                    end else if (bs) begin
                        st    <= RETRACT;
                        valid <= 1'b0;
                    end else if (cl) begin
                        st    <= CLEAR;
                        valid <= 1'b0;
                    end
                end
                RETRACT: begin
                    if (n_entered != '0) begin
                        n_entered <= n_entered - 1'b1;
                        for (int k = 0; k < NDIG_I; k++)
                            if (n_entered == NDIG_W'(k + 1))
                                values[(NDIG_I-1-k)*DIGIT_W +: DIGIT_W] <= '0;
                    end
                    st <= HOLD_BS;
                end
                HOLD_BS: begin
                    if (!bs)
                        st <= IDLE;
                end
                CLEAR: begin
                    n_entered <= '0;
                    if (!cl)
                        st <= IDLE;
                end
                ERROR: begin
                    err <= 1'b1;
                    st  <= IDLE;
                end
                default: begin
                    err <= 1'b1;
                    st  <= ERROR;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_digit_entry_reg.sv
// Scoreboard bench for digit_entry_reg with a 16-bit register of 4-bit digits.
module tb_digit_entry_reg;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  din;
    logic        load_n, backspace_n, clear_n, ready;
    logic [15:0] values;
    logic [2:0]  n_entered;
    logic        valid, err;
    logic [3:0]  state;

    int n_checks = 0;
    int n_fail   = 0;
    int write_cnt = 0;
    int retract_cnt = 0;

    typedef struct {
        string       tag;
        logic [15:0] v;
        logic [2:0]  n;
        logic        vld;
        logic [3:0]  st;
    } exp_t;
    exp_t sb[$];

    digit_entry_reg #(
        .DATA_W(16), .DIGIT_W(4), .NDIG_W(3),
        .RESET_VALUE(16'h0123), .DEBOUNCE_CYC(16'd4)
    ) dut (
        .clk(clk), .rst(rst), .din(din),
        .load_n(load_n), .backspace_n(backspace_n), .clear_n(clear_n),
        .values(values), .n_entered(n_entered), .valid(valid),
        .ready(ready), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (state == 4'd1) write_cnt++;
        if (state == 4'd7) retract_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [15:0] v, input logic [2:0] n,
                            input logic vld, input logic [3:0] st);
        exp_t e;
        e.tag = tag; e.v = v; e.n = n; e.vld = vld; e.st = st;
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        e = sb.pop_front();
        check({e.tag, ".values"}, 32'(values), 32'(e.v));
        check({e.tag, ".n"}, 32'(n_entered), 32'(e.n));
        check({e.tag, ".valid"}, 32'(valid), 32'(e.vld));
        check({e.tag, ".state"}, 32'(state), 32'(e.st));
    endtask

    task automatic wait_state(input logic [3:0] s1, input logic [3:0] s2);
        bit hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (state == s1 || state == s2) hit = 1;
        end
        if (!hit) check("wait_state", 32'(state), 32'(s1));
    endtask

    task automatic enter(input logic [3:0] d);
        din = d;
        load_n = 1'b0;
        wait_state(4'd3, 4'd3);
        repeat (3) @(negedge clk);
        load_n = 1'b1;
        wait_state(4'd0, 4'd5);
    endtask

    task automatic tap_bs();
        backspace_n = 1'b0;
        wait_state(4'd8, 4'd8);
        repeat (2) @(negedge clk);
        backspace_n = 1'b1;
        wait_state(4'd0, 4'd0);
    endtask

    initial begin
        rst = 1'b1; din = '0; ready = 1'b0;
        load_n = 1'b1; backspace_n = 1'b1; clear_n = 1'b1;
        repeat (3) @(negedge clk);
        push_exp("reset", 16'h0123, 3'd0, 1'b0, 4'd0); pop_cmp();
        check("reset.err", 32'(err), 32'd0);
        rst = 1'b0;

        // Reset asserted while the load button is still held.
        din = 4'h5; load_n = 1'b0;
        wait_state(4'd3, 4'd3);
        rst = 1'b1; #1;
        push_exp("rst_mid", 16'h0123, 3'd0, 1'b0, 4'd0); pop_cmp();
        load_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        enter(4'hA); push_exp("dA", 16'hA123, 3'd1, 1'b0, 4'd0); pop_cmp();
        enter(4'hB); push_exp("dB", 16'hAB23, 3'd2, 1'b0, 4'd0); pop_cmp();
        enter(4'hC); push_exp("dC", 16'hABC3, 3'd3, 1'b0, 4'd0); pop_cmp();
        enter(4'hD); push_exp("full", 16'hABCD, 3'd4, 1'b1, 4'd5); pop_cmp();
        repeat (5) @(negedge clk);
        push_exp("full_hold", 16'hABCD, 3'd4, 1'b1, 4'd5); pop_cmp();

        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        push_exp("hs", 16'hABCD, 3'd4, 1'b0, 4'd6); pop_cmp();
        wait_state(4'd0, 4'd0);
        push_exp("hs_idle", 16'hABCD, 3'd0, 1'b0, 4'd0); pop_cmp();

        enter(4'hA); enter(4'hB);
        push_exp("ab", 16'hABCD, 3'd2, 1'b0, 4'd0); pop_cmp();
        tap_bs();
        push_exp("bs", 16'hA0CD, 3'd1, 1'b0, 4'd0); pop_cmp();

        clear_n = 1'b0;
        wait_state(4'd6, 4'd6);
        repeat (2) @(negedge clk);
        clear_n = 1'b1;
        wait_state(4'd0, 4'd0);
        push_exp("clr", 16'hA0CD, 3'd0, 1'b0, 4'd0); pop_cmp();
        tap_bs();
        push_exp("bs_at0", 16'hA0CD, 3'd0, 1'b0, 4'd0); pop_cmp();

        // Load and backspace fall together; load is then held for 1000 cycles.
        write_cnt = 0; retract_cnt = 0;
        din = 4'hE; load_n = 1'b0; backspace_n = 1'b0;
        wait_state(4'd3, 4'd3);
        backspace_n = 1'b1;
        repeat (1000) @(negedge clk);
        load_n = 1'b1;
        wait_state(4'd0, 4'd0);
        repeat (4) @(negedge clk);
        push_exp("ld_bs", 16'hE0CD, 3'd1, 1'b0, 4'd0); pop_cmp();
        check("single_write", 32'(write_cnt), 32'd1);
        check("no_retract", 32'(retract_cnt), 32'd0);

        enter(4'h1); enter(4'h2); enter(4'h3);
        push_exp("full2", 16'hE123, 3'd4, 1'b1, 4'd5); pop_cmp();

        // Time backspace so the FSM sees it on the same edge as ready.
        retract_cnt = 0;
        backspace_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0; backspace_n = 1'b1;
        push_exp("hs_bs", 16'hE123, 3'd4, 1'b0, 4'd6); pop_cmp();
        repeat (6) @(negedge clk);
        push_exp("hs_bs_end", 16'hE123, 3'd0, 1'b0, 4'd0); pop_cmp();
        check("hs_bs_noretract", 32'(retract_cnt), 32'd0);
        check("err_final", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
